tilexy_mort_drain: RTL and testbench

Downstream drain stage for the per-tile cache-line fabric FIFO. It captures each delivered `reqmort` transfer whenever the fabric asserts `outen`, and buffers it in a small in-order queue. It then serialises each 528-bit line into eight 66-bit beats toward the local cache fill/writeback port using a valid/ready handshake. It also returns an almost-full indication so the fabric FIFO can hold delivery.

---
 rtl/tilexy_mort_drain.sv | 101 ++++++++++
 tb/tb_tilexy_mort_drain.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/tilexy_mort_drain.sv
// tilexy_mort_drain: buffers fabric cache-line transfers and serialises each into 66-bit beats.
// Define MORT_PARITY_EN to add per-beat even parity (wr_par) with parity stored at push.
module tilexy_mort_drain #(
   parameter int DEPTH  = 4,
   parameter int ALMOST = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_en,
   input  logic [527:0] in_data,
   input  logic [36:0]  in_addr,
   input  logic [41:0]  in_size,
   input  logic         in_expun,
   output logic         mort_stall,
   output logic         wr_valid,
   input  logic         wr_ready,
   output logic [2:0]   wr_beat,
   output logic [65:0]  wr_data,
   output logic [36:0]  wr_addr,
   output logic [39:0]  wr_phy,
   output logic         wr_shared,
   output logic         wr_excl,
   output logic         wr_expun,
   output logic         wr_first,
   output logic         wr_last,
`ifdef MORT_PARITY_EN
   output logic         wr_par,
`endif
   output logic         ovf_err
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic {IDLE, SEND} state_t;
   state_t       state;
   logic [527:0] mem_data  [DEPTH];
   logic [36:0]  mem_addr  [DEPTH];
   logic [41:0]  mem_size  [DEPTH];
   logic         mem_expun [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0]  cnt;
   logic [2:0]   bc;
   logic [9:0]   off;
   logic         last, pop, push, full;
   always_comb begin
      off  = 10'(bc) * 10'd66;
      last = mem_expun[rp] ? bc == 3'd0 : bc == 3'd7;
      full = cnt == (AW+1)'(DEPTH);
      pop  = wr_valid & wr_ready & last;
      push = in_en & (~full | pop);
   end
   // Outputs decode only registered state; idle forces everything to zero.
   assign wr_valid   = state == SEND;
   assign wr_beat    = wr_valid ? bc : 3'd0;
   assign wr_data    = (wr_valid & ~mem_expun[rp]) ? mem_data[rp][off +: 66] : 66'd0;
   assign wr_addr    = wr_valid ? mem_addr[rp] : 37'd0;
   assign wr_phy     = wr_valid ? mem_size[rp][39:0] : 40'd0;
   assign wr_shared  = wr_valid & mem_size[rp][41];
   assign wr_excl    = wr_valid & mem_size[rp][40];
   assign wr_expun   = wr_valid & mem_expun[rp];
   assign wr_first   = wr_valid & (bc == 3'd0);
   assign wr_last    = wr_valid & last;
   assign mort_stall = (DEPTH - int'(cnt)) <= ALMOST;
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wp]  <= in_data;
         mem_addr[wp]  <= in_addr;
         mem_size[wp]  <= in_size;
         mem_expun[wp] <= in_expun;
      end
   end
`ifdef MORT_PARITY_EN
   logic [7:0] mem_par [DEPTH];
   always_ff @(posedge clk) begin
      if (push)
         for (int k = 0; k < 8; k++) mem_par[wp][k] <= ~in_expun & ^in_data[66*k +: 66];
   end
   assign wr_par = wr_valid & mem_par[rp][bc];
`endif
   // A push into a full queue is still taken when the head pops on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         wp      <= '0;
         rp      <= '0;
         cnt     <= '0;
         bc      <= 3'd0;
         state   <= IDLE;
         ovf_err <= 1'b0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
         if (in_en & ~push) ovf_err <= 1'b1;
         if (state == IDLE) begin
            bc <= 3'd0;
            if (cnt != '0) state <= SEND;
         end else if (wr_ready) begin
            bc <= last ? 3'd0 : bc + 3'd1;
            if (last && cnt == (AW+1)'(1) && !in_en) state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_tilexy_mort_drain.sv
// tb_tilexy_mort_drain: randomized bench with a queue-based reference model of the drain stage.
module tb_tilexy_mort_drain;
   localparam int DEPTH = 4, ALMOST = 1;
   logic clk = 0, rst = 1, in_en = 0, in_expun = 0, wr_ready = 0;
   logic [527:0] in_data = '0;
   logic [36:0]  in_addr = '0;
   logic [41:0]  in_size = '0;
   logic mort_stall, wr_valid, wr_shared, wr_excl, wr_expun, wr_first, wr_last, ovf_err;
   logic [2:0]  wr_beat;
   logic [65:0] wr_data;
   logic [36:0] wr_addr;
   logic [39:0] wr_phy;
   tilexy_mort_drain #(.DEPTH(DEPTH), .ALMOST(ALMOST)) dut (
      .clk(clk), .rst(rst), .in_en(in_en), .in_data(in_data), .in_addr(in_addr),
      .in_size(in_size), .in_expun(in_expun), .mort_stall(mort_stall), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .wr_beat(wr_beat), .wr_data(wr_data), .wr_addr(wr_addr),
      .wr_phy(wr_phy), .wr_shared(wr_shared), .wr_excl(wr_excl), .wr_expun(wr_expun),
      .wr_first(wr_first), .wr_last(wr_last), .ovf_err(ovf_err));
   always #5 clk = ~clk;
   typedef struct packed {logic [527:0] d; logic [36:0] a; logic [41:0] s; logic x;} ent_t;
   ent_t q[$];
   bit m_send = 0, m_ovf = 0, started = 0, pop_now, was_send, lst;
   int m_bc = 0, pre_size, n_cmp = 0, n_bad = 0, hs_total = 0, xp_total = 0;
   // Reference model: a list of whole lines, a sending flag and the index of the beat on offer.
   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         m_send = 0; m_bc = 0; m_ovf = 0; started = 1;
      end else begin
         pre_size = q.size(); was_send = m_send; pop_now = 0;
         if (m_send && wr_ready) begin
            lst = q[0].x ? (m_bc == 0) : (m_bc == 7);
            if (lst) begin void'(q.pop_front()); m_bc = 0; pop_now = 1; end
            else m_bc++;
         end
         if (in_en) begin
            if (q.size() < DEPTH) q.push_back('{in_data, in_addr, in_size, in_expun});
            else m_ovf = 1;
         end
         if (!was_send) m_send = pre_size != 0;
         else if (pop_now) m_send = q.size() != 0;
      end
   end
   always @(posedge clk) begin
      hs_total += int'(wr_valid & wr_ready);
      xp_total += int'(wr_valid & wr_ready & wr_expun);
   end
   function automatic logic [153:0] expv();
      ent_t h;
      logic [65:0] d;
      logic [2:0] b;
      logic f, l, st;
      st = (DEPTH - q.size()) <= ALMOST;
      if (!m_send) return {149'd0, 1'b0, 1'b0, st, m_ovf};
      h = q[0];
      b = 3'(m_bc);
      d = h.x ? 66'd0 : h.d[66*m_bc +: 66];
      f = m_bc == 0;
      l = h.x ? f : (m_bc == 7);
      return {1'b1, b, d, h.a, h.s[39:0], h.s[41], h.s[40], h.x, f, l, st, m_ovf};
   endfunction
   logic [153:0] dv;
   assign dv = {wr_valid, wr_beat, wr_data, wr_addr, wr_phy, wr_shared, wr_excl, wr_expun,
                wr_first, wr_last, mort_stall, ovf_err};
   always @(negedge clk) begin
      if (started) begin
         n_cmp++;
         if (dv !== expv()) begin
            n_bad++;
            $display("FAIL outputs t=%0t got=%h exp=%h", $time, dv, expv());
         end
         n_cmp++;
         if (int'(dut.cnt) != q.size()) begin
            n_bad++;
            $display("FAIL occupancy t=%0t got=%0d exp=%0d", $time, dut.cnt, q.size());
         end
      end
   end
   task automatic chk(input string nm, input logic [65:0] got, input logic [65:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [527:0] rline();
      logic [543:0] t;
      for (int i = 0; i < 17; i++) t[32*i +: 32] = $urandom;
      return t[527:0];
   endfunction
   task automatic push(input logic [527:0] d, input logic x);
      in_data = d;
      in_addr = 37'({$urandom, $urandom});
      in_size = 42'({$urandom, $urandom});
      in_expun = x;
      in_en = 1;
      tick();
      in_en = 0;
   endtask
   task automatic do_reset();
      rst = 1;
      tick();
      rst = 0;
   endtask
   task automatic wait_idle(input string nm);
      int n = 0;
      while ((wr_valid || dut.cnt != 0) && n < 200) begin tick(); n++; end
      chk(nm, 66'(n < 200), 66'd1);
   endtask
   logic [527:0] line;
   int acc, h0, x0, n;
   initial begin
      tick(); tick();
      rst = 0;
      chk("reset_valid", 66'(wr_valid), 66'd0);
      chk("reset_stall", 66'(mort_stall), 66'd0);
      chk("reset_ovf", 66'(ovf_err), 66'd0);
      chk("reset_data", wr_data, 66'd0);
      // Single line at full rate: beat k carries k+1.
      wr_ready = 1;
      for (int k = 0; k < 8; k++) line[66*k +: 66] = 66'(k + 1);
      push(line, 0);
      chk("latency_idle", 66'(wr_valid), 66'd0);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("single_valid", 66'(wr_valid), 66'd1);
         chk("single_beat", 66'(wr_beat), 66'(k));
         chk("single_data", wr_data, 66'(k + 1));
         chk("single_first", 66'(wr_first), 66'(k == 0));
         chk("single_last", 66'(wr_last), 66'(k == 7));
      end
      tick();
      chk("single_done", 66'(wr_valid), 66'd0);
      // Back-pressure with ready pattern 1,0,0.
      wr_ready = 0;
      push(rline(), 0);
      h0 = hs_total; n = 0;
      while ((wr_valid || dut.cnt != 0) && n < 60) begin
         wr_ready = (n % 3) == 0;
         tick(); n++;
      end
      chk("bp_beats", 66'(hs_total - h0), 66'd8);
      // Fill and overflow with the port stalled.
      do_reset();
      wr_ready = 0;
      push(rline(), 0);
      push(rline(), 0);
      chk("fill2_stall", 66'(mort_stall), 66'd0);
      push(rline(), 0);
      chk("fill3_stall", 66'(mort_stall), 66'd1);
      push(rline(), 0);
      chk("fill4_ovf", 66'(ovf_err), 66'd0);
      push(rline(), 0);
      chk("ovf_set", 66'(ovf_err), 66'd1);
      chk("ovf_cnt", 66'(dut.cnt), 66'd4);
      h0 = hs_total;
      wr_ready = 1;
      wait_idle("ovf_drain_timeout");
      chk("ovf_drain_beats", 66'(hs_total - h0), 66'd32);
      chk("ovf_sticky", 66'(ovf_err), 66'd1);
      // Expunge, data, expunge.
      do_reset();
      h0 = hs_total; x0 = xp_total;
      push(rline(), 1);
      push(rline(), 0);
      push(rline(), 1);
      wait_idle("mix_timeout");
      chk("mix_beats", 66'(hs_total - h0), 66'd10);
      chk("mix_expun_beats", 66'(xp_total - x0), 66'd2);
      // Full queue, push lands on the last-beat handshake.
      do_reset();
      wr_ready = 0;
      for (int i = 0; i < 4; i++) push(rline(), 0);
      wr_ready = 1;
      n = 0;
      while (!(wr_valid && wr_last) && n < 20) begin tick(); n++; end
      chk("full_pop_found_last", 66'(n < 20), 66'd1);
      push(rline(), 0);
      chk("full_pop_ovf", 66'(ovf_err), 66'd0);
      chk("full_pop_cnt", 66'(dut.cnt), 66'd4);
      wait_idle("full_pop_timeout");
      // Reset in the middle of an entry.
      push(rline(), 0);
      n = 0;
      while (!(wr_valid && wr_beat == 3'd3) && n < 20) begin tick(); n++; end
      chk("mid_found_beat3", 66'(n < 20), 66'd1);
      do_reset();
      chk("mid_valid", 66'(wr_valid), 66'd0);
      chk("mid_last", 66'(wr_last), 66'd0);
      chk("mid_data", wr_data, 66'd0);
      chk("mid_cnt", 66'(dut.cnt), 66'd0);
      push(rline(), 0);
      tick();
      chk("mid_restart_valid", 66'(wr_valid), 66'd1);
      chk("mid_restart_beat", 66'(wr_beat), 66'd0);
      wait_idle("mid_timeout");
      // Random traffic.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         in_en = ($urandom % 3) == 0;
         in_expun = ($urandom % 4) == 0;
         in_data = rline();
         in_addr = 37'({$urandom, $urandom});
         in_size = 42'({$urandom, $urandom});
         wr_ready = (c % 500) < 250 ? ($urandom % 4) != 0 : ($urandom % 4) == 0;
         tick();
      end
      in_en = 0;
      wr_ready = 1;
      wait_idle("rand_drain_timeout");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
